// File: rtl/regfile_cmd_ctrl.sv
// Byte-stream command controller: turns UART RX frames into register file
// write/read strobes and returns read data to the UART TX path.
module regfile_cmd_ctrl #(
    parameter int               WIDTH  = 8,
    parameter int               ADDR   = 4,
    parameter logic [WIDTH-1:0] WR_CMD = 8'hAA,
    parameter logic [WIDTH-1:0] RD_CMD = 8'hBB,
    parameter int               RD_TMO = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] RX_P_DATA,
    input  logic             RX_D_VLD,
    input  logic [WIDTH-1:0] RdData,
    input  logic             RdData_Valid,
    input  logic             TX_Busy,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] TX_P_DATA,
    output logic             TX_D_VLD,
    output logic             Cmd_Err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ADDR = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] RD_ADDR = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;
    localparam logic [2:0] TX_SEND = 3'd5;

    localparam int CW = $clog2(RD_TMO + 1);

    logic [2:0]       state_reg,   state_next;
    logic [CW-1:0]    tmo_cnt_reg, tmo_cnt_next;
    logic [ADDR-1:0]  addr_reg,    addr_next;
    logic [WIDTH-1:0] wr_data_reg, wr_data_next;
    logic [WIDTH-1:0] tx_data_reg, tx_data_next;
    logic             wr_en_reg,   wr_en_next;
    logic             rd_en_reg,   rd_en_next;
    logic             tx_vld_reg,  tx_vld_next;
    logic             cmd_err_reg, cmd_err_next;

    // An address byte is only legal if it fits the register file.
    logic addr_bad;
    assign addr_bad = |RX_P_DATA[WIDTH-1:ADDR];

    always_comb begin
        state_next   = state_reg;
        tmo_cnt_next = tmo_cnt_reg;
        addr_next    = addr_reg;
        wr_data_next = wr_data_reg;
        tx_data_next = tx_data_reg;
        wr_en_next   = 1'b0;
        rd_en_next   = 1'b0;
        tx_vld_next  = 1'b0;
        cmd_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD)      state_next = WR_ADDR;
                    else if (RX_P_DATA == RD_CMD) state_next = RD_ADDR;
                    else                          cmd_err_next = 1'b1;
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_bad) begin
                        cmd_err_next = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        addr_next = RX_P_DATA[ADDR-1:0];
                        if (state_reg == WR_ADDR) begin
                            state_next = WR_DATA;
                        end else begin
                            state_next   = RD_WAIT;
                            rd_en_next   = 1'b1;
                            tmo_cnt_next = '0;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_next = RX_P_DATA;
                    wr_en_next   = 1'b1;
                    state_next   = IDLE;
                end
            end
            RD_WAIT: begin
                // A stray RX byte is flagged but does not disturb the pending read.
                if (RX_D_VLD) cmd_err_next = 1'b1;
                if (RdData_Valid) begin
                    tx_data_next = RdData;
                    state_next   = TX_SEND;
                end else if (tmo_cnt_reg == CW'(RD_TMO - 1)) begin
                    cmd_err_next = 1'b1;
                    tmo_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            TX_SEND: begin
                if (RX_D_VLD) cmd_err_next = 1'b1;
                if (!TX_Busy) begin
                    tx_vld_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg   <= IDLE;
            tmo_cnt_reg <= '0;
            addr_reg    <= '0;
            wr_data_reg <= '0;
            tx_data_reg <= '0;
            wr_en_reg   <= 1'b0;
            rd_en_reg   <= 1'b0;
            tx_vld_reg  <= 1'b0;
            cmd_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tmo_cnt_reg <= tmo_cnt_next;
            addr_reg    <= addr_next;
            wr_data_reg <= wr_data_next;
            tx_data_reg <= tx_data_next;
            wr_en_reg   <= wr_en_next;
            rd_en_reg   <= rd_en_next;
            tx_vld_reg  <= tx_vld_next;
            cmd_err_reg <= cmd_err_next;
        end
    end

    assign WrEn      = wr_en_reg;
    assign RdEn      = rd_en_reg;
    assign Address   = addr_reg;
    assign WrData    = wr_data_reg;
    assign TX_P_DATA = tx_data_reg;
    assign TX_D_VLD  = tx_vld_reg;
    assign Cmd_Err   = cmd_err_reg;

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Directed bench for regfile_cmd_ctrl with a small register-file model
// that answers RdEn one cycle later.
module tb_regfile_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = 8'h00;
    logic       RX_D_VLD = 1'b0;
    logic [7:0] RdData = 8'h00;
    logic       RdData_Valid = 1'b0;
    logic       TX_Busy = 1'b0;
    logic       WrEn, RdEn, TX_D_VLD, Cmd_Err;
    logic [3:0] Address;
    logic [7:0] WrData, TX_P_DATA;

    regfile_cmd_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_Busy(TX_Busy),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .Cmd_Err(Cmd_Err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Monitor state, sampled 1 time unit after each rising edge.
    int cyc = 0;
    int n_wr, n_rd, n_tx, n_err, n_both;
    int wr_cyc, rd_cyc, tx_cyc, err_cyc, rx_cyc, fall_cyc;
    logic [7:0] wr_addr, wr_data, tx_data;
    logic [7:0] rf_mem [16];
    logic       model_en = 1'b1;
    logic       rd_pend = 1'b0;
    logic [3:0] rd_addr_pend = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_mon();
        n_wr = 0; n_rd = 0; n_tx = 0; n_err = 0; n_both = 0;
        wr_cyc = 0; rd_cyc = 0; tx_cyc = 0; err_cyc = 0;
        wr_addr = 8'h00; wr_data = 8'h00; tx_data = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        rx_cyc    = cyc;
        $display("RX byte %02h at cycle %0d", b, cyc);
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    always @(posedge CLK) begin
        #1;
        cyc++;
        if (WrEn) begin
            n_wr++; wr_cyc = cyc; wr_addr = {4'h0, Address}; wr_data = WrData;
            rf_mem[Address] = WrData;
        end
        if (RdEn) begin n_rd++; rd_cyc = cyc; end
        if (TX_D_VLD) begin n_tx++; tx_cyc = cyc; tx_data = TX_P_DATA; end
        if (Cmd_Err) begin n_err++; err_cyc = cyc; end
        if (WrEn && RdEn) n_both++;
        RdData_Valid = rd_pend;
        RdData       = rf_mem[rd_addr_pend];
        rd_pend      = RdEn && model_en;
        rd_addr_pend = Address;
    end

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;
        rf_mem[2] = 8'h81;
        clr_mon();

        // Reset state
        idle_cycles(3);
        chk("rst_wren",  32'(WrEn), 0);
        chk("rst_rden",  32'(RdEn), 0);
        chk("rst_addr",  32'(Address), 0);
        chk("rst_wdata", 32'(WrData), 0);
        chk("rst_txdata", 32'(TX_P_DATA), 0);
        chk("rst_txvld", 32'(TX_D_VLD), 0);
        chk("rst_err",   32'(Cmd_Err), 0);
        RST = 1'b1;
        idle_cycles(2);

        // Write AA,03,5C
        clr_mon();
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h5C);
        idle_cycles(4);
        $display("write frame: WrEn pulses %0d addr %0h data %0h", n_wr, wr_addr, wr_data);
        chk("wr_count", 32'(n_wr), 1);
        chk("wr_addr",  32'(wr_addr), 32'h3);
        chk("wr_data",  32'(wr_data), 32'h5C);
        chk("wr_lat",   32'(wr_cyc - rx_cyc), 1);
        chk("wr_no_tx", 32'(n_tx), 0);
        chk("wr_no_err", 32'(n_err), 0);
        chk("wr_no_rd", 32'(n_rd), 0);

        // Read BB,02 with TX idle
        clr_mon();
        send_byte(8'hBB); send_byte(8'h02);
        idle_cycles(6);
        $display("read frame: TX pulses %0d data %0h", n_tx, tx_data);
        chk("rd_count", 32'(n_rd), 1);
        chk("rd_tx_cnt", 32'(n_tx), 1);
        chk("rd_tx_data", 32'(tx_data), 32'h81);
        chk("rd_no_err", 32'(n_err), 0);

        // Read with TX backpressure
        clr_mon();
        TX_Busy = 1'b1;
        send_byte(8'hBB); send_byte(8'h02);
        idle_cycles(10);
        chk("bp_no_tx",  32'(n_tx), 0);
        chk("bp_hold",   32'(TX_P_DATA), 32'h81);
        TX_Busy  = 1'b0;
        fall_cyc = cyc;
        idle_cycles(4);
        $display("backpressure frame: TX pulses %0d data %0h", n_tx, tx_data);
        chk("bp_tx_cnt", 32'(n_tx), 1);
        chk("bp_tx_lat", 32'(tx_cyc - fall_cyc), 1);
        chk("bp_tx_data", 32'(tx_data), 32'h81);

        // Bad command byte, then bad address
        clr_mon();
        send_byte(8'h7E);
        idle_cycles(2);
        chk("badcmd_err", 32'(n_err), 1);
        clr_mon();
        send_byte(8'hAA); send_byte(8'h1F);
        idle_cycles(3);
        $display("bad address frame: Cmd_Err pulses %0d WrEn pulses %0d", n_err, n_wr);
        chk("badaddr_err", 32'(n_err), 1);
        chk("badaddr_nowr", 32'(n_wr), 0);

        // Back in IDLE: two back-to-back writes
        clr_mon();
        send_byte(8'hAA); send_byte(8'h04); send_byte(8'h33);
        send_byte(8'hAA); send_byte(8'h06); send_byte(8'h44);
        idle_cycles(3);
        $display("back-to-back writes: WrEn pulses %0d last addr %0h data %0h", n_wr, wr_addr, wr_data);
        chk("b2b_count", 32'(n_wr), 2);
        chk("b2b_addr",  32'(wr_addr), 32'h6);
        chk("b2b_data",  32'(wr_data), 32'h44);
        chk("b2b_rf4",   32'(rf_mem[4]), 32'h33);
        chk("b2b_err",   32'(n_err), 0);

        // Read timeout, with a stray byte during RD_WAIT
        clr_mon();
        model_en = 1'b0;
        send_byte(8'hBB); send_byte(8'h01); send_byte(8'h55);
        idle_cycles(25);
        $display("timeout frame: RdEn cycle %0d Cmd_Err cycle %0d", rd_cyc, err_cyc);
        chk("tmo_rd",    32'(n_rd), 1);
        chk("tmo_delay", 32'(err_cyc - rd_cyc), 15);
        chk("tmo_errs",  32'(n_err), 2);
        chk("tmo_no_tx", 32'(n_tx), 0);
        model_en = 1'b1;
        clr_mon();
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'h99);
        idle_cycles(3);
        chk("tmo_idle_wr", 32'(n_wr), 1);

        // Reset in the middle of a write frame
        clr_mon();
        send_byte(8'hAA); send_byte(8'h05);
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK); RST = 1'b1;
        chk("mid_rst_addr", 32'(Address), 0);
        send_byte(8'h22);
        idle_cycles(3);
        chk("mid_rst_nowr", 32'(n_wr), 0);
        chk("mid_rst_err",  32'(n_err), 1);
        clr_mon();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h22);
        idle_cycles(3);
        $display("post-reset write: WrEn pulses %0d addr %0h data %0h", n_wr, wr_addr, wr_data);
        chk("post_rst_wr",   32'(n_wr), 1);
        chk("post_rst_addr", 32'(wr_addr), 32'h5);
        chk("post_rst_data", 32'(wr_data), 32'h22);
        chk("never_both",    32'(n_both), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
